sme_feeder: RTL and testbench
=============================

# sme_feeder

Upstream front end for the SME string-match engine. It accepts a byte stream of framed records (strings and patterns) over a valid/ready handshake and buffers each whole record. It then replays the record to SME as a contiguous `chardata` burst with `isstring`/`ispattern` asserted. After every pattern it waits for SME's `valid` and republishes the match result as a one-cycle pulse.

## Interface
Parameters:
- `STR_MAX`, 32: longest string, in characters.
- `PAT_MAX`, 8: longest pattern, in characters.
- `BUF_DEPTH`, 64: byte-buffer entries; power of two, at least `STR_MAX+PAT_MAX`.
- `DESC_DEPTH`, 4: record-descriptor entries; power of two.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream byte valid.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `in_data`  in  8  character byte.
- `in_kind`  in  1  0 = string, 1 = pattern; sampled on the first byte of a record.
- `in_last`  in  1  marks the final byte of a record.
- `chardata`  out  8  character to SME.
- `isstring`  out  1  string character strobe to SME.
- `ispattern`  out  1  pattern character strobe to SME.
- `sme_valid`  in  1  SME result valid.
- `sme_match`  in  1  SME match flag.
- `sme_index`  in  5  SME match index.
- `res_valid`  out  1  one-cycle result pulse.
- `res_match`  out  1  latched match flag.
- `res_index`  out  5  latched match index.
- `drop_err`  out  1  one-cycle pulse: a byte beyond the kind's maximum length was discarded.
- `busy`  out  1  FSM not in IDLE, or descriptor FIFO non-empty.

## Operation
- **Byte FIFO.** Each accepted byte is written, up to the kind's maximum length.
  - Bytes beyond `STR_MAX`/`PAT_MAX` are accepted but not written, and `drop_err` pulses for each one.
  - The length counter is 6 bits and saturates at the maximum.
- **Descriptor FIFO.** On `in_last`, push `{kind, len}`, where `len` is the stored count, range 1..max.
- **`in_ready`.** Asserted when the byte FIFO has at least 1 free entry and the descriptor FIFO has at least 1 free entry. It is combinational from occupancy counts only and does not depend on `in_valid`.
- **FSM states:** IDLE, SEND_STR, SEND_PAT, WAIT_RES.
  - IDLE: if the descriptor FIFO is non-empty, pop it, load the down-counter with `len`, and go to SEND_STR or SEND_PAT by `kind`.
  - SEND_*: each cycle, pop one byte to `chardata` and assert the matching strobe. After `len` bytes:
    - SEND_STR returns to IDLE.
    - SEND_PAT goes to WAIT_RES.
  - WAIT_RES: on `sme_valid`, register `sme_match`/`sme_index` into `res_match`/`res_index`, pulse `res_valid`, and go to IDLE.
- `sme_valid` outside WAIT_RES is ignored.
- A pattern with no preceding string is forwarded unchanged; behaviour then belongs to SME.
- Only complete records are replayed, so a burst never stalls mid-record.

## Timing
- **Reset values:** `chardata`=0, `isstring`=0, `ispattern`=0, `res_valid`=0, `res_match`=0, `res_index`=0, `drop_err`=0, `busy`=0. Both FIFOs are empty and the FSM is in IDLE.
- **Reset mid-operation:** all state clears immediately, including a partially received or partially sent record; SME sees its strobes drop asynchronously.
- **Output registration:** all SME-side outputs and all result outputs are registered.
- **Minimum latency:** last byte accepted in cycle N → descriptor visible in N+1 → popped in N+1 → first char and strobe driven in N+2.
- **Burst timing:** a burst of length L occupies L consecutive cycles, followed by at least one cycle with both strobes low before the next burst.
- **Patterns:** no further record starts until the cycle after `res_valid`.
- **Result timing:** `res_valid` is asserted the cycle after `sme_valid` is sampled in WAIT_RES. `res_match` and `res_index` hold until the next result.
- **Simultaneous FIFO push and pop:** allowed in both FIFOs; occupancy stays unchanged.
- **Full FIFO:** `in_ready`=0.
- **Empty descriptor FIFO:** FSM stays in IDLE.

## Structure
- **Shared package `sme_pkg`:** `kind_e` (KIND_STR, KIND_PAT), `feeder_state_e`, `STR_MAX`/`PAT_MAX` defaults, and a `desc_t` struct `{kind_e kind; logic [5:0] len;}`.
- **Sub-module `sme_sync_fifo`:** parameterised width and depth, with count output. It is instantiated twice: 8-bit for bytes, `desc_t` for descriptors.

## Test plan
- Reset, then string "ABCD" followed by pattern "BC":
  - `isstring` high for exactly 4 cycles carrying 41,42,43,44.
  - One gap cycle, then `ispattern` high for 2 cycles.
  - SME model returns (1,1) → `res_valid` pulse with `res_match`=1, `res_index`=1.
- A 40-byte string record → 32 chars forwarded and 8 `drop_err` pulses.
- Back-to-back records with `in_valid` held high and a stalled SME (`sme_valid` withheld 100 cycles):
  - `in_ready` drops once the descriptor FIFO holds 4 records.
  - Resumes after `res_valid`; no byte is lost or reordered.
- `sme_valid` pulsed while in IDLE and while in SEND_STR → no `res_valid`.
- Reset asserted mid-burst on char 3 of 8 → strobes 0 immediately, FIFOs empty. The next record after release is forwarded intact.

Source files
------------

// File: rtl/sme_pkg.sv
// Shared types and defaults for the SME front end: record kinds, feeder
// states and the record descriptor that links the byte and descriptor FIFOs.
package sme_pkg;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;

  typedef enum logic {
    KIND_STR = 1'b0,
    KIND_PAT = 1'b1
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_STR = 2'd1,
    ST_SEND_PAT = 2'd2,
    ST_WAIT_RES = 2'd3
  } feeder_state_e;

  typedef struct packed {
    kind_e      kind;
    logic [5:0] len;
  } desc_t;

  function automatic logic [5:0] kind_limit(input kind_e k, input logic [5:0] str_lim,
                                            input logic [5:0] pat_lim);
    return (k == KIND_PAT) ? pat_lim : str_lim;
  endfunction

endpackage

// File: rtl/sme_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; o_rdata is the head entry.
// Push on a full FIFO is ignored unless a pop happens in the same cycle.
module sme_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/sme_feeder.sv
// Buffers framed string/pattern records and replays each whole record to SME
// as a contiguous strobed burst, then republishes SME's result after patterns.
//
// state    | meaning
// IDLE     | wait for a complete record; pop it together with its first byte
// SEND_STR | string burst in progress, isstring high
// SEND_PAT | pattern burst in progress, ispattern high
// WAIT_RES | pattern sent, waiting for sme_valid
module sme_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX    = STR_MAX_DEF,
  parameter int PAT_MAX    = PAT_MAX_DEF,
  parameter int BUF_DEPTH  = 64,
  parameter int DESC_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       drop_err,
  output logic       busy
);

  localparam int BCW = $clog2(BUF_DEPTH) + 1;
  localparam int DCW = $clog2(DESC_DEPTH) + 1;
  localparam logic [5:0] STR_LIM = 6'(STR_MAX);
  localparam logic [5:0] PAT_LIM = 6'(PAT_MAX);

  logic [BCW-1:0]            w_bcnt;
  logic [DCW-1:0]            w_dcnt;
  logic [7:0]                w_byte_out;
  logic [$bits(desc_t)-1:0]  w_desc_raw;
  desc_t                     w_desc_out;
  desc_t                     w_desc_in;
  logic                      w_acc;
  logic                      w_store;
  kind_e                     w_kind;
  logic [5:0]                w_cur;
  logic [5:0]                w_new_len;
  logic                      w_byte_pop;
  logic                      w_desc_pop;

  logic                      r_first;
  kind_e                     r_kind;
  logic [5:0]                r_len;
  logic                      r_drop;

  assign in_ready   = (w_bcnt < BCW'(BUF_DEPTH)) && (w_dcnt < DCW'(DESC_DEPTH));
  assign w_acc      = in_valid && in_ready;
  assign w_kind     = r_first ? kind_e'(in_kind) : r_kind;
  assign w_cur      = r_first ? 6'd0 : r_len;
  assign w_store    = w_acc && (w_cur < kind_limit(w_kind, STR_LIM, PAT_LIM));
  assign w_new_len  = w_cur + {5'd0, w_store};
  assign w_desc_in  = '{kind: w_kind, len: w_new_len};
  assign w_desc_out = w_desc_raw;

  // Over-length bytes are still accepted so the record framing stays intact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_first <= 1'b1;
      r_kind  <= KIND_STR;
      r_len   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_acc && !w_store;
      if (w_acc) begin
        r_first <= in_last;
        r_kind  <= w_kind;
        r_len   <= w_new_len;
      end
    end
  end

  sme_sync_fifo #(.WIDTH(8), .DEPTH(BUF_DEPTH)) u_byte_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_store),
    .i_wdata (in_data),
    .i_pop   (w_byte_pop),
    .o_rdata (w_byte_out),
    .o_count (w_bcnt)
  );

  sme_sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_acc && in_last),
    .i_wdata (w_desc_in),
    .i_pop   (w_desc_pop),
    .o_rdata (w_desc_raw),
    .o_count (w_dcnt)
  );

  feeder_state_e r_state, w_state_nx;
  logic [5:0]    r_cnt, w_cnt_nx;
  logic [7:0]    r_chardata, w_char_nx;
  logic          r_isstring, w_str_nx;
  logic          r_ispattern, w_pat_nx;
  logic          r_res_valid, w_resv_nx;
  logic          r_res_match, w_resm_nx;
  logic [4:0]    r_res_index, w_resi_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_chardata  <= '0;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_chardata  <= w_char_nx;
      r_isstring  <= w_str_nx;
      r_ispattern <= w_pat_nx;
      r_res_valid <= w_resv_nx;
      r_res_match <= w_resm_nx;
      r_res_index <= w_resi_nx;
    end
  end

  // r_cnt holds the bytes still to send after the one being driven now.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_char_nx  = r_chardata;
    w_str_nx   = 1'b0;
    w_pat_nx   = 1'b0;
    w_resv_nx  = 1'b0;
    w_resm_nx  = r_res_match;
    w_resi_nx  = r_res_index;
    w_byte_pop = 1'b0;
    w_desc_pop = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dcnt != '0) begin
          w_desc_pop = 1'b1;
          w_byte_pop = 1'b1;
          w_char_nx  = w_byte_out;
          w_cnt_nx   = w_desc_out.len - 6'd1;
          if (w_desc_out.kind == KIND_PAT) begin
            w_pat_nx   = 1'b1;
            w_state_nx = ST_SEND_PAT;
          end else begin
            w_str_nx   = 1'b1;
            w_state_nx = ST_SEND_STR;
          end
        end
      end
      ST_SEND_STR, ST_SEND_PAT: begin
        if (r_cnt != '0) begin
          w_byte_pop = 1'b1;
          w_char_nx  = w_byte_out;
          w_cnt_nx   = r_cnt - 6'd1;
          w_str_nx   = (r_state == ST_SEND_STR);
          w_pat_nx   = (r_state == ST_SEND_PAT);
        end else begin
          w_state_nx = (r_state == ST_SEND_PAT) ? ST_WAIT_RES : ST_IDLE;
        end
      end
      ST_WAIT_RES: begin
        if (sme_valid) begin
          w_resv_nx  = 1'b1;
          w_resm_nx  = sme_match;
          w_resi_nx  = sme_index;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign chardata  = r_chardata;
  assign isstring  = r_isstring;
  assign ispattern = r_ispattern;
  assign res_valid = r_res_valid;
  assign res_match = r_res_match;
  assign res_index = r_res_index;
  assign drop_err  = r_drop;
  assign busy      = (r_state != ST_IDLE) || (w_dcnt != '0);

endmodule

// File: tb/tb_sme_feeder.sv
// Scoreboard bench for sme_feeder: stimulus queues expected chars, bursts and
// results; a negedge monitor and a small SME responder check the DUT side.
`timescale 1ns/1ps
module tb_sme_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       in_kind = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_index;
  logic       res_valid, res_match;
  logic [4:0] res_index;
  logic       drop_err, busy;

  logic       sv_model = 1'b0, sv_poke = 1'b0;
  logic       sm_model = 1'b0, sm_poke = 1'b0;
  logic [4:0] si_model = 5'd0, si_poke = 5'd0;

  assign sme_valid = sv_model | sv_poke;
  assign sme_match = sv_model ? sm_model : sm_poke;
  assign sme_index = sv_model ? si_model : si_poke;

  always #5 clk = ~clk;

  sme_feeder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kind(in_kind), .in_last(in_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
    .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
    .drop_err(drop_err), .busy(busy)
  );

  typedef struct {bit m; bit [4:0] idx; int c;} res_t;

  int total = 0, bad = 0;
  int cyc = 0, acc_cnt = 0, drop_seen = 0, res_seen = 0, last_gap = 0;
  bit [8:0] exp_chr[$];
  int       exp_burst[$];
  res_t     exp_res[$];
  res_t     plan[$];
  int       sme_delay = 2;
  bit       last_m = 1'b0;
  bit [4:0] last_i = 5'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset && in_valid && in_ready) acc_cnt++;
  end

  // Scoreboard monitor
  initial begin
    int run, run_kind, gap, cur;
    bit seen, pending;
    run = 0; run_kind = 0; gap = 0; seen = 0; pending = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run = 0; run_kind = 0; gap = 0; seen = 0; pending = 0;
        continue;
      end
      cur = isstring ? 1 : (ispattern ? 2 : 0);
      if (isstring || ispattern) chk("one_strobe", {31'd0, isstring && ispattern}, 0);
      if (run > 0 && cur != run_kind) begin
        if (exp_burst.size() == 0) chk("burst_extra", 1, 0);
        else chk("burst_len", ((run_kind == 2) ? 256 : 0) + run, exp_burst.pop_front());
        if (run_kind == 2) pending = 1;
        run = 0; gap = 0;
      end
      if (cur != 0) begin
        if (run == 0) begin
          if (seen) chk("gap_min", {31'd0, gap >= 1}, 1);
          chk("start_after_res", {31'd0, pending}, 0);
          last_gap = gap;
          seen = 1;
        end
        run++;
        run_kind = cur;
        if (exp_chr.size() == 0) chk("chr_extra", 1, 0);
        else chk("chr", {23'd0, cur == 2, chardata}, {23'd0, exp_chr.pop_front()});
      end else begin
        gap++;
      end
      if (res_valid) begin
        res_t e;
        res_seen++;
        pending = 0;
        if (exp_res.size() == 0) chk("res_extra", 1, 0);
        else begin
          e = exp_res.pop_front();
          chk("res_match", {31'd0, res_match}, {31'd0, e.m});
          chk("res_index", {27'd0, res_index}, {27'd0, e.idx});
          chk("res_latency", cyc, e.c + 1);
        end
      end
      if (drop_err) drop_seen++;
    end
  end

  // SME responder: answers after each pattern burst ends
  initial begin
    bit prev;
    res_t r;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin prev = 0; continue; end
      if (prev && !ispattern) begin
        r = (plan.size() != 0) ? plan.pop_front() : '{0, 0, 0};
        repeat (sme_delay) @(negedge clk);
        sm_model = r.m; si_model = r.idx; sv_model = 1'b1;
        r.c = cyc;
        exp_res.push_back(r);
        last_m = r.m; last_i = r.idx;
        @(negedge clk);
        sv_model = 1'b0;
      end
      prev = ispattern;
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit k, input bit l);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_kind = k; in_last = l;
    guard = 0;
    while (!in_ready && guard < 5000) begin @(negedge clk); guard++; end
    if (guard >= 5000) chk("in_ready_timeout", 1, 0);
    @(posedge clk);
  endtask

  task automatic send_rec(input bit k, input int base, input int len);
    int lim, stored;
    logic [7:0] b;
    lim = k ? 8 : 32;
    stored = (len < lim) ? len : lim;
    for (int i = 0; i < stored; i++) begin
      b = 8'(base + i);
      exp_chr.push_back({k, b});
    end
    exp_burst.push_back((k ? 256 : 0) + stored);
    for (int i = 0; i < len; i++) send_byte(8'(base + i), k, i == len - 1);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((busy || exp_chr.size() != 0 || exp_res.size() != 0 || sv_model) && guard < 3000) begin
      @(negedge clk); guard++;
    end
    if (guard >= 3000) chk("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, guard;
    #1;
    chk("rst_chardata", {24'd0, chardata}, 0);
    chk("rst_strobes", {30'd0, isstring, ispattern}, 0);
    chk("rst_res", {25'd0, res_valid, res_match, res_index}, 0);
    chk("rst_drop_busy", {30'd0, drop_err, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // "ABCD" then "BC": latency, contents, single gap, result
    sme_delay = 2;
    plan.push_back('{1, 5'd1, 0});
    send_rec(0, 'h41, 4);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("lat_n1_strobe", {31'd0, isstring}, 0);
    @(negedge clk);
    chk("lat_n2_first", {23'd0, isstring, chardata}, {23'd0, 1'b1, 8'h41});
    send_rec(1, 'h42, 2);
    idle_in();
    drain();
    chk("gap_exact", last_gap, 1);

    // over-length string and pattern
    d0 = drop_seen;
    plan.push_back('{0, 5'd2, 0});
    send_rec(0, 'h20, 40);
    send_rec(1, 'h50, 9);
    idle_in();
    drain();
    chk("drop_count", drop_seen - d0, 9);

    // stalled SME, back-to-back records with in_valid held high
    sme_delay = 100;
    plan.push_back('{0, 5'd5, 0});
    d0 = acc_cnt;
    fork
      begin
        send_rec(1, 'h61, 3);
        for (int k = 0; k < 5; k++) send_rec(0, 'h30 + 4 * k, 4);
        idle_in();
      end
      begin
        repeat (60) @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 0);
        chk("stall_accepted", acc_cnt - d0, 19);
        chk("stall_busy", {31'd0, busy}, 1);
      end
    join
    drain();

    // sme_valid outside WAIT_RES is ignored
    r0 = res_seen;
    @(negedge clk);
    sv_poke = 1'b1; sm_poke = 1'b1; si_poke = 5'd9;
    @(negedge clk);
    sv_poke = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_res_idle", res_seen - r0, 0);
    send_rec(0, 'h60, 8);
    idle_in();
    guard = 0;
    while (!isstring && guard < 50) begin @(negedge clk); guard++; end
    chk("str_seen", {31'd0, isstring}, 1);
    sv_poke = 1'b1; sm_poke = 1'b1; si_poke = 5'd9;
    @(negedge clk);
    sv_poke = 1'b0;
    repeat (15) @(negedge clk);
    chk("no_res_send", res_seen - r0, 0);
    chk("res_hold", {26'd0, res_match, res_index}, {26'd0, last_m, last_i});
    drain();

    // reset mid-burst on char 3 of 8
    send_rec(0, 'h50, 8);
    idle_in();
    guard = 0;
    while (!(isstring && chardata == 8'h52) && guard < 50) begin @(negedge clk); guard++; end
    chk("mid_burst_char3", {23'd0, isstring, chardata}, {23'd0, 1'b1, 8'h52});
    #2 reset = 1'b0;
    #1;
    exp_chr.delete();
    exp_burst.delete();
    chk("mid_rst_strobes", {30'd0, isstring, ispattern}, 0);
    chk("mid_rst_chardata", {24'd0, chardata}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    sme_delay = 0;
    plan.push_back('{1, 5'd3, 0});
    send_rec(0, 'h70, 5);
    send_rec(1, 'h75, 2);
    idle_in();
    drain();

    chk("end_chr_q", exp_chr.size(), 0);
    chk("end_burst_q", exp_burst.size(), 0);
    chk("end_res_q", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
